// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding and default sizing.
package period_meter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArm     = 2'd1,
    StMeasure = 2'd2
  } state_e;

  localparam int unsigned DefCntW      = 24;
  localparam int unsigned DefTimeout   = 1000000;
  localparam int unsigned DefMinPeriod = 4;

endpackage

// File: rtl/period_meter_if.sv
// Result channel of the period meter: measured values plus valid/ready handshake.
interface period_meter_if import period_meter_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW
) ();

  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH_TIME;
  logic             VALID;
  logic             READY;

  modport master (
    output PERIOD,
    output HIGH_TIME,
    output VALID,
    input  READY
  );

  modport slave (
    input  PERIOD,
    input  HIGH_TIME,
    input  VALID,
    output READY
  );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus single-cycle edge pulses.
module edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability catcher, [1] synchronized level, [2] level one cycle earlier
  logic [2:0] sync_q;

  // Shift the raw input through the synchronizer and keep the previous level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave, in CLK cycles.
// A rising edge closes one measurement and opens the next in the same cycle.
module period_meter import period_meter_pkg::*; #(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned TIMEOUT    = DefTimeout,
  parameter int unsigned MIN_PERIOD = DefMinPeriod
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SIG_IN,
  input  logic          EN,
  period_meter_if.master res,
  output logic          TIMEOUT_FLAG,
  output logic          OVERRUN
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MinCnt     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic sync_level;
  logic sync_rise;
  logic unused_fall;

  edge_sync u_edge_sync (
    .CLK     (CLK),
    .RST     (RST),
    .sig_i   (SIG_IN),
    .level_o (sync_level),
    .rise_o  (sync_rise),
    .fall_o  (unused_fall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;
  logic             overrun_q;

  logic [CNT_W-1:0] period_inc;
  logic [CNT_W-1:0] high_inc;

  // Counter values including the current cycle; the closing edge cycle belongs to the period.
  always_comb begin
    period_inc = period_cnt_q + One;
    high_inc   = high_cnt_q;
    if (sync_level) begin
      high_inc = high_cnt_q + One;
    end
  end

  // Control FSM with counters, result registers and sticky flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // Consumption first; a publish later in this block overrides it.
      if (valid_q && res.READY) begin
        valid_q <= 1'b0;
      end

      if (!EN) begin
        state_q      <= StIdle;
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        overrun_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StArm;
          end
          StArm: begin
            // First edge only opens a measurement.
            if (sync_rise) begin
              period_cnt_q <= '0;
              high_cnt_q   <= '0;
              state_q      <= StMeasure;
            end
          end
          StMeasure: begin
            if (sync_rise) begin
              period_cnt_q <= '0;
              high_cnt_q   <= '0;
              // Too-short periods are glitches: dropped silently, measurement goes on.
              if (period_inc >= MinCnt) begin
                if (valid_q && !res.READY) begin
                  overrun_q <= 1'b1;
                end else begin
                  period_q  <= period_inc;
                  high_q    <= high_inc;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b0;
                end
              end
            end else if (period_inc >= TimeoutCnt) begin
              // Counters park at the limit; next edge re-arms from scratch.
              period_cnt_q <= TimeoutCnt;
              high_cnt_q   <= high_inc;
              timeout_q    <= 1'b1;
              state_q      <= StArm;
            end else begin
              period_cnt_q <= period_inc;
              high_cnt_q   <= high_inc;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign res.PERIOD    = period_q;
  assign res.HIGH_TIME = high_q;
  assign res.VALID     = valid_q;
  assign TIMEOUT_FLAG  = timeout_q;
  assign OVERRUN       = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected results, a monitor pops them.
module tb_period_meter;

  localparam int unsigned CntW = 16;
  localparam int unsigned Tmo  = 500;
  localparam int unsigned MinP = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sig;
  logic en;
  logic tflag;
  logic ovr;

  period_meter_if #(.CNT_W(CntW)) bus ();

  period_meter #(
    .CNT_W      (CntW),
    .TIMEOUT    (Tmo),
    .MIN_PERIOD (MinP)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .SIG_IN       (sig),
    .EN           (en),
    .res          (bus.master),
    .TIMEOUT_FLAG (tflag),
    .OVERRUN      (ovr)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned period;
    int unsigned high;
  } res_t;

  res_t        exp_q[$];
  bit          armed;
  int unsigned t_prev;
  int unsigned h_prev;
  bit          exp_ovr;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model, called at every SIG_IN rise the bench drives. Period is the distance
  // between consecutive rises; high time is the high phase that started at the previous rise.
  function automatic void model_rise(input int unsigned h, input bit ready_at_pub);
    int unsigned p;
    if (armed) begin
      p = cyc - t_prev;
      // p > Tmo: the meter timed out before this edge, so the edge only re-arms.
      if (p <= Tmo && p >= MinP) begin
        if (exp_q.size() > 0 && !ready_at_pub) exp_ovr = 1'b1;
        else exp_q.push_back('{period: p, high: h_prev});
      end
    end
    armed  = 1'b1;
    t_prev = cyc;
    h_prev = h;
  endfunction

  task automatic rise_hold(input int unsigned h, input bit rdy_pub);
    sig = 1'b1;
    model_rise(h, rdy_pub);
    repeat (h) tick();
    sig = 1'b0;
  endtask

  task automatic sig_cycle(input int unsigned h, input int unsigned l);
    rise_hold(h, bus.READY);
    repeat (l) tick();
  endtask

  // Monitor: consumption compares against the scoreboard; held results must stay stable.
  logic            hold_v = 1'b0;
  logic [CntW-1:0] hold_p;
  logic [CntW-1:0] hold_h;
  res_t            mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", bus.VALID, 1);
        check("hold_period", bus.PERIOD, hold_p);
        check("hold_high", bus.HIGH_TIME, hold_h);
      end
      if (bus.VALID && bus.READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got period %0d high %0d, required no result",
                   bus.PERIOD, bus.HIGH_TIME);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_period", bus.PERIOD, mon_e.period);
          check("result_high", bus.HIGH_TIME, mon_e.high);
        end
        check("high_le_period", (bus.HIGH_TIME <= bus.PERIOD) ? 1 : 0, 1);
      end
      hold_v = bus.VALID && !bus.READY;
      hold_p = bus.PERIOD;
      hold_h = bus.HIGH_TIME;
    end
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: got no end of stimulus, required finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    sig       = 1'b0;
    en        = 1'b0;
    bus.READY = 1'b1;
    armed     = 1'b0;
    exp_ovr   = 1'b0;
    repeat (3) tick();
    check("rst_period", bus.PERIOD, 0);
    check("rst_high", bus.HIGH_TIME, 0);
    check("rst_valid", bus.VALID, 0);
    check("rst_timeout", tflag, 0);
    check("rst_overrun", ovr, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    tick();

    // Steady 100/30 wave: first edge arms, then one result per period.
    repeat (4) sig_cycle(30, 70);
    check("basic_drain", exp_q.size(), 0);

    // Consumer stalls across three periods: first result held, later ones dropped.
    bus.READY = 1'b0;
    repeat (3) sig_cycle(30, 70);
    check("stall_overrun", ovr, exp_ovr);
    check("stall_valid", bus.VALID, 1);
    check("stall_period", bus.PERIOD, 100);
    check("stall_high", bus.HIGH_TIME, 30);
    bus.READY = 1'b1;
    tick();
    bus.READY = 1'b0;
    check("stall_release_valid", bus.VALID, 0);
    check("stall_drain", exp_q.size(), 0);
    bus.READY = 1'b1;

    // Disabling clears overrun and forces re-arming.
    en = 1'b0;
    tick();
    en      = 1'b1;
    armed   = 1'b0;
    exp_ovr = 1'b0;
    tick();
    check("en_clears_overrun", ovr, exp_ovr);

    // Two-cycle glitch period is discarded.
    sig_cycle(30, 70);
    sig_cycle(30, 70);
    sig_cycle(1, 1);
    sig_cycle(30, 70);
    sig_cycle(30, 70);
    check("glitch_overrun", ovr, 0);
    check("glitch_drain", exp_q.size(), 0);

    // READY in the very cycle a new result lands: old consumed, new published, no overrun.
    bus.READY = 1'b0;
    sig_cycle(20, 57);
    sig = 1'b1;
    model_rise(30, 1'b1);
    tick();
    tick();
    bus.READY = 1'b1;
    tick();
    bus.READY = 1'b0;
    check("same_cycle_valid", bus.VALID, 1);
    check("same_cycle_period", bus.PERIOD, 77);
    check("same_cycle_high", bus.HIGH_TIME, 20);
    check("same_cycle_overrun", ovr, 0);
    repeat (27) tick();
    sig = 1'b0;
    repeat (70) tick();
    bus.READY = 1'b1;
    tick();
    tick();
    check("same_cycle_drain", exp_q.size(), 0);

    // Input stuck low: flag rises exactly TIMEOUT cycles after the last edge.
    rise_hold(30, 1'b1);
    repeat (472) tick();
    check("timeout_early", tflag, 0);
    tick();
    check("timeout_set", tflag, 1);
    check("timeout_no_valid", bus.VALID, 0);
    repeat (50) tick();
    sig_cycle(30, 70);
    check("timeout_after_arm", tflag, 1);
    sig_cycle(30, 70);
    check("timeout_cleared", tflag, 0);
    check("timeout_drain", exp_q.size(), 0);

    // Reset mid-measurement wipes everything; two edges needed afterwards.
    repeat (20) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_period", bus.PERIOD, 0);
    check("midrst_high", bus.HIGH_TIME, 0);
    check("midrst_valid", bus.VALID, 0);
    check("midrst_timeout", tflag, 0);
    check("midrst_overrun", ovr, 0);
    armed   = 1'b0;
    exp_ovr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tick();
    sig_cycle(30, 70);
    check("midrst_first_edge", bus.VALID, 0);
    sig_cycle(30, 70);
    check("midrst_drain", exp_q.size(), 0);

    // Randomized waveforms, including sub-minimum glitches and timeouts.
    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      int unsigned h;
      int unsigned l;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        h = $urandom_range(1, 2);
        l = $urandom_range(1, 3);
      end else if (kind == 1) begin
        h = $urandom_range(1, 40);
        l = $urandom_range(505, 600);
      end else begin
        h = $urandom_range(1, 60);
        l = $urandom_range(1, 80);
      end
      sig_cycle(h, l);
    end
    repeat (10) tick();
    check("random_drain", exp_q.size(), 0);
    check("random_overrun", ovr, exp_ovr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
